fetch_decode_skid_reg: RTL

//  Parametrised IF->ID pipeline boundary: a DEPTH-entry elastic buffer carrying {instr, pc, pc_plus}.

---
 rtl/fd_pkg.sv | 41 ++++
 rtl/pipe_fifo.sv | 92 +++++++++
 rtl/fetch_decode_skid_reg.sv | 77 +++++++
 3 files changed

// File: rtl/fd_pkg.sv
// Shared types and constants for the fetch -> decode pipeline boundary.
// The payload struct, the bubble constant and the FIFO operation encoding
// live here so the buffer, its storage sub-module and neighbouring stages
// agree on field order and on what an empty decode slot looks like.
package fd_pkg;

    // Default field width of instr, pc and pc_plus.
    localparam int FD_DATA_WIDTH = 32;

    // Default number of buffer entries; two lets fetch run one beat ahead
    // of a stalled decode without a combinational ready path.
    localparam int FD_DEPTH = 2;

    // addi x0,x0,0 -- the instruction decode sees while the buffer is empty.
    localparam logic [FD_DATA_WIDTH-1:0] FD_NOP_INSTR = 32'h0000_0013;

    // One transfer across the IF->ID boundary, instr in the top bits.
    typedef struct packed {
        logic [FD_DATA_WIDTH-1:0] instr;
        logic [FD_DATA_WIDTH-1:0] pc;
        logic [FD_DATA_WIDTH-1:0] pc_plus;
    } fd_payload_t;

    // What the storage does in a given cycle, encoded as {pop, push}.
    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_PUSH = 2'b01,
        FIFO_POP  = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_t;

    // Payload presented to decode when there is no valid head entry.
    function automatic fd_payload_t bubble();
        fd_payload_t b;
        b.instr   = FD_NOP_INSTR;
        b.pc      = '0;
        b.pc_plus = '0;
        return b;
    endfunction

endpackage

// File: rtl/pipe_fifo.sv
// Generic elastic storage: DEPTH entries of WIDTH bits, wrap-around read and
// write pointers, an occupancy count and full/empty flags. DEPTH need not be
// a power of two; pointers wrap by comparing against DEPTH-1. A synchronous
// clear empties the buffer and outranks any push or pop in the same cycle.
module pipe_fifo
    import fd_pkg::*;
#(
    parameter int WIDTH = 96,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;
    fifo_op_t         op;

    // Advance a pointer by one, wrapping from the last entry back to zero.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Flags come straight from the registered count so no input reaches them.
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Guard both operations so the count can neither overflow nor underflow.
    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty & ~clear;
    assign op      = fifo_op_t'({do_pop, do_push});

    assign rdata = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; clear drops every entry at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            case (op)
                FIFO_PUSH: begin
                    wr_ptr <= wrap_inc(wr_ptr);
                    count  <= count + CNT_W'(1);
                end
                FIFO_POP: begin
                    rd_ptr <= wrap_inc(rd_ptr);
                    count  <= count - CNT_W'(1);
                end
                FIFO_BOTH: begin
                    wr_ptr <= wrap_inc(wr_ptr);
                    rd_ptr <= wrap_inc(rd_ptr);
                end
                default: begin
                    count <= count;
                end
            endcase
        end
    end

    // Entry storage needs no reset: an entry is only visible once counted.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_decode_skid_reg.sv
// IF->ID pipeline boundary built as a small elastic buffer. Fetch pushes
// {instr, pc, pc_plus} with a valid/ready handshake, decode pops the head.
// A redirect flush empties the buffer and kills any coincident fetch beat.
// While empty, decode sees a NOP bubble with zero PCs rather than stale data.
// in_ready depends only on the registered count, so there is no
// combinational path from out_ready back to the fetch side.
module fetch_decode_skid_reg
    import fd_pkg::*;
#(
    parameter int                    DATA_WIDTH = FD_DATA_WIDTH,
    parameter int                    DEPTH      = FD_DEPTH,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(FD_NOP_INSTR)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      InstrF,
    input  logic [DATA_WIDTH-1:0]      PCF,
    input  logic [DATA_WIDTH-1:0]      PC_PlusF,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      InstrD,
    output logic [DATA_WIDTH-1:0]      PCD,
    output logic [DATA_WIDTH-1:0]      PC_PlusD,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PAY_W = 3 * DATA_WIDTH;

    logic             enq;
    logic             deq;
    logic             fifo_full;
    logic             fifo_empty;
    logic [PAY_W-1:0] wr_payload;
    logic [PAY_W-1:0] head_payload;

    // Handshake status is derived purely from stored occupancy.
    assign in_ready  = ~fifo_full;
    assign out_valid = ~fifo_empty;

    // A flush wins over both sides of the handshake in the same cycle.
    assign enq = in_valid & in_ready & ~flush;
    assign deq = out_valid & out_ready & ~flush;

    assign wr_payload = {InstrF, PCF, PC_PlusF};

    pipe_fifo #(
        .WIDTH (PAY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (enq),
        .pop   (deq),
        .wdata (wr_payload),
        .rdata (head_payload),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Show the head entry when valid, otherwise a NOP bubble with zero PCs.
    always_comb begin
        InstrD   = NOP_INSTR;
        PCD      = '0;
        PC_PlusD = '0;
        if (out_valid) begin
            InstrD   = head_payload[3*DATA_WIDTH-1:2*DATA_WIDTH];
            PCD      = head_payload[2*DATA_WIDTH-1:DATA_WIDTH];
            PC_PlusD = head_payload[DATA_WIDTH-1:0];
        end
    end

endmodule
